// File: rtl/delay_ram_pkg.sv
// Shared constants and types for the delay_ram block.
// Holds the default geometry and the state type used by the optional clear sequencer.
package delay_ram_pkg;

    localparam int DEFAULT_ADDRESS_WIDTH = 9;
    localparam int DEFAULT_DATA_WIDTH    = 8;
    localparam int DEFAULT_NUM_TAPS      = 2;

    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } clear_state_e;

endpackage

// File: rtl/ram_1w1r.sv
// Synchronous one-write/one-read RAM with write-first bypass on an address collision.
// The read data register clears on reset and holds whenever re is low.
module ram_1w1r #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [ADDRESS_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];

    // NOTE: the array has no reset branch so it maps onto block RAM; only the output register is reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking here, so the read below sees the old contents and the bypass supplies the new value.
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/delay_ram.sv
// Multi-tap circular delay line: one write and one read per tap on every en strobe.
// Define DELAY_RAM_CLEAR_EN to add the clr/busy ports and the memory-clearing sequencer.
module delay_ram
    import delay_ram_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int NUM_TAPS      = DEFAULT_NUM_TAPS
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   en,
`ifdef DELAY_RAM_CLEAR_EN
    input  logic                                   clr,
    output logic                                   busy,
`endif
    input  logic [DATA_WIDTH-1:0]                  din,
    input  logic [NUM_TAPS-1:0][ADDRESS_WIDTH-1:0] delay,
    output logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]    dout,
    output logic [NUM_TAPS-1:0]                    dout_valid,
    output logic [ADDRESS_WIDTH-1:0]               wr_ptr,
    output logic                                   primed
);

    localparam int                 DEPTH    = 2**ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] FILL_MAX = (ADDRESS_WIDTH+1)'(DEPTH);

    logic                     strobe;
    logic                     clear_done;
    logic                     ram_we;
    logic [ADDRESS_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0]    ram_wdata;
    logic [ADDRESS_WIDTH:0]   fill_count;

`ifdef DELAY_RAM_CLEAR_EN
    clear_state_e             state;
    logic [ADDRESS_WIDTH-1:0] clr_addr;

    // A clear request in IDLE takes priority over a sample; while clearing, en and clr are ignored.
    assign strobe     = en && !clr && (state == IDLE);
    assign clear_done = (state == CLEARING) && (clr_addr == '1);
    assign ram_we     = strobe || (state == CLEARING);
    assign ram_waddr  = (state == CLEARING) ? clr_addr : wr_ptr;
    assign ram_wdata  = (state == CLEARING) ? '0 : din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            clr_addr <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr) begin
                        state    <= CLEARING;
                        clr_addr <= '0;
                        busy     <= 1'b1;
                    end
                end
                CLEARING: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == '1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
`else
    assign strobe     = en;
    assign clear_done = 1'b0;
    assign ram_we     = en;
    assign ram_waddr  = wr_ptr;
    assign ram_wdata  = din;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            fill_count <= '0;
            dout_valid <= '0;
        end else if (clear_done) begin
            wr_ptr     <= '0;
            fill_count <= '0;
        end else if (strobe) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (fill_count != FILL_MAX) begin
                fill_count <= fill_count + 1'b1;
            end
            // Validity is judged against the fill level before this sample lands.
            for (int k = 0; k < NUM_TAPS; k++) begin
                dout_valid[k] <= (fill_count >= {1'b0, delay[k]});
            end
        end
    end

    assign primed = (fill_count == FILL_MAX);

    // Every tap has its own copy of the history so each gets an independent read port.
    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        logic [ADDRESS_WIDTH-1:0] rd_addr;
        logic [DATA_WIDTH-1:0]    rd_data;

        assign rd_addr = wr_ptr - delay[k];

        ram_1w1r #(
            .ADDRESS_WIDTH(ADDRESS_WIDTH),
            .DATA_WIDTH   (DATA_WIDTH)
        ) u_ram (
            .clk  (clk),
            .rst  (rst),
            .we   (ram_we),
            .waddr(ram_waddr),
            .wdata(ram_wdata),
            .re   (strobe),
            .raddr(rd_addr),
            .rdata(rd_data)
        );

        assign dout[k] = rd_data;
    end

endmodule

// File: tb/tb_delay_ram.sv
// Directed self-checking bench for delay_ram with the default geometry (512 x 8, 2 taps).
// Clear-sequencer checks are compiled in only when DELAY_RAM_CLEAR_EN is defined.
module tb_delay_ram;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
`ifdef DELAY_RAM_CLEAR_EN
    logic            clr;
    logic            busy;
`endif
    logic [7:0]      din;
    logic [1:0][8:0] delay;
    logic [1:0][7:0] dout;
    logic [1:0]      dout_valid;
    logic [8:0]      wr_ptr;
    logic            primed;

    int n_checks = 0;
    int n_pass   = 0;

    delay_ram dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
`ifdef DELAY_RAM_CLEAR_EN
        .clr       (clr),
        .busy      (busy),
`endif
        .din       (din),
        .delay     (delay),
        .dout      (dout),
        .dout_valid(dout_valid),
        .wr_ptr    (wr_ptr),
        .primed    (primed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One en strobe; outputs are sampled 1 time unit after the capturing edge.
    task automatic strobe(input logic [7:0] d, input logic [8:0] d0, input logic [8:0] d1);
        en       = 1'b1;
        din      = d;
        delay[0] = d0;
        delay[1] = d1;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        din      = '0;
        delay    = '0;
`ifdef DELAY_RAM_CLEAR_EN
        clr      = 1'b0;
`endif
        #2;
        check("reset_wr_ptr", 32'(wr_ptr), 32'd0);
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_valid", 32'(dout_valid), 32'd0);
        check("reset_primed", 32'(primed), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Three strobes, taps at delay 0 and 2.
        strobe(8'd10, 9'd0, 9'd2);
        strobe(8'd20, 9'd0, 9'd2);
        check("s2_valid", 32'(dout_valid), 32'b01);
        strobe(8'd30, 9'd0, 9'd2);
        check("s3_dout0", 32'(dout[0]), 32'd30);
        check("s3_dout1", 32'(dout[1]), 32'd10);
        check("s3_valid", 32'(dout_valid), 32'b11);
        check("s3_wr_ptr", 32'(wr_ptr), 32'd3);

        // en low with delay churning: everything holds.
        for (int i = 0; i < 10; i++) begin
            delay[0] = 9'(i + 1);
            delay[1] = 9'(300 + i);
            din      = 8'(i);
            @(posedge clk);
            #1;
        end
        check("hold_dout0", 32'(dout[0]), 32'd30);
        check("hold_dout1", 32'(dout[1]), 32'd10);
        check("hold_wr_ptr", 32'(wr_ptr), 32'd3);
        check("hold_valid", 32'(dout_valid), 32'b11);

        // Tap 1 at delay 4 becomes valid on the 5th strobe and returns the first sample.
        do_reset();
        strobe(8'd5, 9'd0, 9'd4);
        check("d4_s1_valid1", 32'(dout_valid[1]), 32'd0);
        check("d4_s1_dout0", 32'(dout[0]), 32'd5);
        for (int i = 2; i <= 4; i++) begin
            strobe(8'(i + 4), 9'd0, 9'd4);
            check($sformatf("d4_s%0d_valid1", i), 32'(dout_valid[1]), 32'd0);
        end
        strobe(8'd9, 9'd0, 9'd4);
        check("d4_s5_valid1", 32'(dout_valid[1]), 32'd1);
        check("d4_s5_dout1", 32'(dout[1]), 32'd5);
        check("d4_s5_dout0", 32'(dout[0]), 32'd9);

        // Fill the whole buffer, then read across the wrap point.
        do_reset();
        for (int i = 0; i < 511; i++) begin
            strobe(8'(i), 9'd0, 9'd0);
        end
        check("fill511_primed", 32'(primed), 32'd0);
        strobe(8'd255, 9'd0, 9'd0);
        check("fill512_primed", 32'(primed), 32'd1);
        check("fill512_wr_ptr", 32'(wr_ptr), 32'd0);
        strobe(8'hAA, 9'd511, 9'd1);
        check("wrap_dout0", 32'(dout[0]), 32'd1);
        check("wrap_dout1", 32'(dout[1]), 32'd255);
        check("wrap_wr_ptr", 32'(wr_ptr), 32'd1);
        check("wrap_valid", 32'(dout_valid), 32'b11);
        check("wrap_primed", 32'(primed), 32'd1);

`ifdef DELAY_RAM_CLEAR_EN
        begin
            int busy_cycles;
            do_reset();
            for (int i = 0; i < 600; i++) begin
                strobe(8'(i + 1), 9'd0, 9'd0);
            end
            clr = 1'b1;
            en  = 1'b1;
            din = 8'h77;
            @(posedge clk);
            #1;
            clr = 1'b0;
            // en stays high through the clear and must be ignored.
            busy_cycles = 0;
            while (busy && busy_cycles < 1000) begin
                busy_cycles++;
                @(posedge clk);
                #1;
            end
            en = 1'b0;
            check("clr_busy_cycles", 32'(busy_cycles), 32'd512);
            check("clr_wr_ptr", 32'(wr_ptr), 32'd0);
            check("clr_primed", 32'(primed), 32'd0);
            strobe(8'd3, 9'd100, 9'd0);
            check("clr_dout0", 32'(dout[0]), 32'd0);
            check("clr_valid0", 32'(dout_valid[0]), 32'd0);
            check("clr_dout1", 32'(dout[1]), 32'd3);

            // Reset in the middle of a clear aborts it.
            clr = 1'b1;
            @(posedge clk);
            #1;
            clr = 1'b0;
            repeat (200) @(posedge clk);
            #1;
            rst = 1'b1;
            #1;
            check("rst_clr_busy", 32'(busy), 32'd0);
            @(negedge clk);
            rst = 1'b0;
            strobe(8'd7, 9'd0, 9'd0);
            check("rst_clr_dout0", 32'(dout[0]), 32'd7);
            check("rst_clr_wr_ptr", 32'(wr_ptr), 32'd1);
            check("rst_clr_busy2", 32'(busy), 32'd0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/delay_ram.md
DELAY_RAM -- requirements
Module: delay_ram

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 9: buffer depth DEPTH = 2**ADDRESS_WIDTH samples.
REQ-002 Parameter DATA_WIDTH, default 8: sample width.
REQ-003 Parameter NUM_TAPS, default 2: number of independent read taps.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  sample strobe; one write and one read per tap when high.
REQ-007 din  input  DATA_WIDTH  sample to write.
REQ-008 delay  input  NUM_TAPS x ADDRESS_WIDTH  per-tap delay in samples, packed array, tap 0 in LSBs.
REQ-009 dout  output  NUM_TAPS x DATA_WIDTH  registered per-tap delayed sample.
REQ-010 dout_valid  output  NUM_TAPS  per-tap flag: dout holds real history, not stale or uninitialised memory.
REQ-011 wr_ptr  output  ADDRESS_WIDTH  current write address.
REQ-012 primed  output  1  high once DEPTH samples have been written since reset or clear.

Function
REQ-013 On a cycle with en=1, the block SHALL write din to address wr_ptr and increment wr_ptr modulo DEPTH.
REQ-014 On the same edge, for each tap k, dout[k] SHALL load the sample at address (wr_ptr - delay[k]) mod DEPTH, using wr_ptr before the increment. Latency is 1 cycle.
REQ-015 delay[k]=0 SHALL return the din written on the same edge (write-first bypass). delay[k]=d SHALL return the sample written d strobes earlier.
REQ-016 With en=0, wr_ptr, dout, dout_valid and fill_count SHALL hold.
REQ-017 An internal fill_count (ADDRESS_WIDTH+1 bits) SHALL increment on each en and saturate at DEPTH. primed SHALL be (fill_count == DEPTH).
REQ-018 dout_valid[k] SHALL load (fill_count >= delay[k]) on each en edge, using fill_count before its increment. delay 0 is therefore always valid.
REQ-019 delay[k] SHALL be sampled only on en edges. A change between strobes SHALL have no effect until the next en.
REQ-020 Wrap-around: wr_ptr DEPTH-1 -> 0. Read address arithmetic SHALL be modulo DEPTH with no saturation.

Reset
REQ-021 rst=1 SHALL asynchronously force wr_ptr=0, fill_count=0, dout=0, dout_valid=0 and primed=0; memory contents are not reset.
REQ-022 rst asserted mid-operation, including during a clear, SHALL abort all activity. The first en after release SHALL write address 0.

Configuration
REQ-023 Macro DELAY_RAM_CLEAR_EN, when defined, SHALL add input clr (1 bit) and output busy (1 bit), together with an FSM with states IDLE and CLEARING.
REQ-024 Clear FSM behaviour:
- clr=1 in IDLE SHALL enter CLEARING.
- CLEARING writes 0 to one address per cycle, ascending from 0, for DEPTH cycles, with busy=1.
- After the last address, the FSM returns to IDLE with wr_ptr=0 and fill_count=0.
- In CLEARING, en and clr SHALL be ignored and dout/dout_valid SHALL hold.
- clr and en both high in IDLE: clr wins and no sample is written.
REQ-025 Without DELAY_RAM_CLEAR_EN, the clr and busy ports and the FSM SHALL be absent; behaviour is otherwise identical.

Structure
REQ-026 A shared package delay_ram_pkg SHALL hold the clear-FSM state enum and the default parameter constants.
REQ-027 Storage SHALL be NUM_TAPS instances of sub-module ram_1w1r (synchronous 1-write/1-read, write-first). All instances are written identically; each serves one tap.

Verification
REQ-028 Reset, then 3 strobes with din=10,20,30 and delay={0,2} -> after 3rd edge: dout[0]=30, dout[1]=10, dout_valid=2'b11.
REQ-029 After reset, first strobe din=5, delay[1]=4 -> dout_valid[1]=0 until the 5th strobe, then dout[1]=5.
REQ-030 Write 512 strobes din=index[7:0], then 1 more with delay[0]=511 -> primed=1, wr_ptr wraps to 1, dout[0]=1.
REQ-031 en held low for 10 cycles with delay changing -> dout, wr_ptr, dout_valid unchanged.
REQ-032 With DELAY_RAM_CLEAR_EN defined, after 600 strobes pulse clr -> busy=1 for exactly 512 cycles. Next strobe with delay[0]=100 -> dout[0]=0 and dout_valid[0]=0.
REQ-033 Assert rst at clear cycle 200 -> busy=0 immediately. After release, one strobe din=7 with delay 0 -> dout[0]=7, wr_ptr=1.
